// File: rtl/ps2_kbd_tx.sv
// Device-side PS/2 transmitter: queues scan-code bytes in a small FIFO and
// serialises each as an 11-bit frame (start, 8 data LSB first, odd parity, stop).
module ps2_kbd_tx #(
    parameter int HALF_PERIOD = 8,
    parameter int GAP         = 16,
    parameter int FIFO_DEPTH  = 4
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [7:0]                    in_data,
    input  logic                          in_valid,
    output logic                          in_ready,
    output logic                          ps2_clk,
    output logic                          ps2_data,
    output logic                          busy,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_count
);
    localparam int AW   = $clog2(FIFO_DEPTH);
    localparam int PMAX = (HALF_PERIOD > GAP) ? HALF_PERIOD : GAP;
    localparam int PW   = $clog2(PMAX);

    localparam logic [PW-1:0] H_LAST = PW'(HALF_PERIOD - 1);
    localparam logic [PW-1:0] G_LAST = PW'(GAP - 1);
    localparam logic [AW:0]   FULL   = (AW + 1)'(FIFO_DEPTH);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_HI   = 2'd1;
    localparam logic [1:0] S_LO   = 2'd2;
    localparam logic [1:0] S_GAP  = 2'd3;

    logic [7:0]    mem [FIFO_DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [AW:0]   count;
    logic [1:0]    state;
    logic [PW-1:0] phase;
    logic [3:0]    bit_idx;
    logic [7:0]    shreg;
    logic [10:0]   frame;
    logic          cur_bit;
    logic          push;
    logic          pop;

    assign in_ready   = (count != FULL);
    assign fifo_count = count;
    assign push       = in_valid && in_ready;
    assign pop        = (state == S_IDLE) && (count != '0);

    always_comb begin
        frame   = {1'b1, ~^shreg, shreg, 1'b0};
        cur_bit = frame[bit_idx];
    end

    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= in_data;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            case ({push, pop})
                2'b10:   count <= count + (AW + 1)'(1);
                2'b01:   count <= count - (AW + 1)'(1);
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= S_IDLE;
            phase   <= '0;
            bit_idx <= '0;
            shreg   <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    phase <= '0;
                    if (pop) begin
                        shreg   <= mem[rd_ptr];
                        bit_idx <= '0;
                        state   <= S_HI;
                    end
                end
                S_HI: begin
                    if (phase == H_LAST) begin
                        phase <= '0;
                        state <= S_LO;
                    end else begin
                        phase <= phase + PW'(1);
                    end
                end
                S_LO: begin
                    if (phase == H_LAST) begin
                        phase <= '0;
                        if (bit_idx == 4'd10) begin
                            state <= S_GAP;
                        end else begin
                            bit_idx <= bit_idx + 4'd1;
                            state   <= S_HI;
                        end
                    end else begin
                        phase <= phase + PW'(1);
                    end
                end
                default: begin
                    if (phase == G_LAST) begin
                        phase <= '0;
                        state <= S_IDLE;
                    end else begin
                        phase <= phase + PW'(1);
                    end
                end
            endcase
        end
    end

    // Lines are registered from the current state, so they trail the FSM by one cycle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ps2_clk  <= 1'b1;
            ps2_data <= 1'b1;
            busy     <= 1'b0;
        end else begin
            ps2_clk  <= (state != S_LO);
            ps2_data <= ((state == S_HI) || (state == S_LO)) ? cur_bit : 1'b1;
            busy     <= (state != S_IDLE);
        end
    end

endmodule

// File: doc/ps2_kbd_tx.md
# ps2_kbd_tx

Device-side PS/2 transmitter: accepts scan-code bytes on a valid/ready input, buffers them in a small FIFO, and serialises each one as an 11-bit PS/2 frame on generated `ps2_clk`/`ps2_data` lines. It is the keyboard end of the link whose host end is the existing `ps2_keyboard` receiver. It drives that receiver in simulation and loopback tests without an external keyboard model.

## Interface
Parameters:
- `HALF_PERIOD`, default 8: `clk` cycles per half-period of `ps2_clk`. Must be at least 2.
- `GAP`, default 16: idle `clk` cycles between the end of one frame and the start of the next. Must be at least 1.
- `FIFO_DEPTH`, default 4: byte FIFO depth. Must be a power of 2 and at least 2.

Ports:
- `clk`  in  1  system clock; all logic is on its rising edge.
- `rst`  in  1  reset; asynchronous and active-high.
- `in_data`  in  8  scan-code byte to send.
- `in_valid`  in  1  `in_data` is valid.
- `in_ready`  out  1  FIFO can accept a byte; equals (count != FIFO_DEPTH).
- `ps2_clk`  out  1  generated PS/2 clock; idles high.
- `ps2_data`  out  1  PS/2 data; idles high.
- `busy`  out  1  high from the first cycle of a frame through the last cycle of its post-frame gap.
- `fifo_count`  out  $clog2(FIFO_DEPTH)+1  number of bytes queued, excluding the byte being sent.

## Operation
- Push: a byte is written when `in_valid && in_ready` at a rising edge. When full, `in_ready` is 0 and `in_data` is ignored. Bytes leave the FIFO in the order they were pushed.
- Frame format: start bit 0, then `d[0]`…`d[7]` (LSB first), then odd parity `~^d`, then stop bit 1. That is 11 bits.
- Each bit is `2*HALF_PERIOD` cycles long:
  - `ps2_data` takes the bit value at the start of the bit.
  - `ps2_clk` is 1 for the first HALF_PERIOD cycles, then 0 for the next HALF_PERIOD cycles.
  - The host samples on the falling edge of `ps2_clk`, HALF_PERIOD cycles after the data change.
- FSM states:
  - IDLE: `ps2_clk`=1, `ps2_data`=1, `busy`=0. If the FIFO is non-empty, pop one byte into the shift register and load the bit index to 0. Go to HI.
  - HI: `ps2_clk`=1 and `ps2_data`=current bit. After HALF_PERIOD cycles, go to LO.
  - LO: `ps2_clk`=0. After HALF_PERIOD cycles: if bit index is 10, go to GAP; otherwise increment the index and go to HI.
  - GAP: `ps2_clk`=1, `ps2_data`=1, `busy`=1. After GAP cycles, go to IDLE.
- `ps2_clk`, `ps2_data` and `busy` are registered outputs.
- Counters:
  - Phase counter width is $clog2(max(HALF_PERIOD,GAP)). It resets to 0 on every state change.
  - Bit index counts 0–10 and never wraps past 10.
- FIFO: read and write pointers wrap modulo FIFO_DEPTH. A push and a pop in the same cycle leave `fifo_count` unchanged. A pop can only occur in IDLE, so an empty-FIFO pop is impossible.

## Timing
- Reset values:
  - `ps2_clk`=1, `ps2_data`=1, `busy`=0, `fifo_count`=0, `in_ready`=1.
  - FSM in IDLE; FIFO pointers 0.
- Reset asserted mid-frame: the lines go idle-high immediately (asynchronously), and the FIFO and the in-flight byte are discarded. No partial frame is resumed after release.
- Latency: a byte pushed at edge t into an empty FIFO with the FSM in IDLE is popped at edge t+1. `ps2_data` falls (start bit) and `busy` rises after edge t+2.
- Frame duration: 22*HALF_PERIOD cycles from the start-bit data change to the end of the stop-bit low phase. Then GAP cycles follow.
- Back-to-back bytes: the next start bit begins exactly 22*HALF_PERIOD + GAP + 1 cycles after the previous one. The extra cycle is the IDLE pop.
- `in_ready` is combinational from the registered count, with no dependency on `in_valid`.
- A push in the same cycle as a pop from a full FIFO is not possible, because `in_ready` is 0 that cycle. The freed slot shows as `in_ready`=1 one cycle after the pop.

## Test plan
- Single byte 0x1C, HALF_PERIOD=8: sampling `ps2_data` on the 11 `ps2_clk` falling edges gives 0,0,0,1,1,1,0,0,0,0,1 (parity 0). Exactly 11 falling edges occur. `busy` is high for 176+16 cycles.
- Byte 0x00: parity bit is 1. Byte 0xFF: parity bit is 1. Byte 0x01: parity bit is 0. Stop bit is 1 in every case.
- Burst of 6 bytes with `in_valid` held high, starting from idle, FIFO_DEPTH=4:
  - The first 5 bytes are accepted on consecutive edges (byte 1 is popped immediately).
  - `in_ready` falls after the 5th byte.
  - The 6th byte is accepted one cycle after the second pop.
  - All 6 bytes appear on the line in order, with start bits 193 cycles apart.
- Reset after the 4th data bit of byte 0xAA, with 2 bytes queued:
  - Both lines read 1 in the same cycle reset is asserted.
  - `fifo_count`=0 and `busy`=0.
  - No further `ps2_clk` edges occur after release until a new push.
- Loopback into the team's `ps2_keyboard` receiver (`resetn`=~`rst`, same `clk`) with the sequence 0x1C, 0xF0, 0x1C: the receiver captures 0x1C, 0xF0, 0x1C in order with no parity error.
